// File: rtl/ddr4_axi_ar_channel_mo_if.sv
// ddr4_axi_ar_channel_mo_if
//   Groups the AXI AR handshake, the MC read-command port and the R-channel tag
//   port of the multi-outstanding AR channel.
//   slave  : view used by ddr4_axi_ar_channel_mo (AR/cmd_full/R status in; ready/cmd/tags out)
//   master : view used by whatever drives the AR channel and consumes commands and tags
interface ddr4_axi_ar_channel_mo_if #(
  parameter int unsigned C_ID_WIDTH        = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_MC_ADDR_WIDTH   = 30,
  parameter int unsigned C_MAX_OUTSTANDING = 4
);
  localparam int unsigned OstWidth = $clog2(C_MAX_OUTSTANDING + 1);

  // AXI read address channel
  logic [C_ID_WIDTH-1:0]       arid;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                  arlen;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  // Memory-controller command port
  logic                        cmd_en;
  logic [2:0]                  cmd_instr;
  logic [C_MC_ADDR_WIDTH-1:0]  cmd_byte_addr;
  logic                        cmd_full;
  // R-channel tag port and status
  logic                        r_data_rdy;
  logic                        r_burst_done;
  logic                        r_push;
  logic [C_ID_WIDTH-1:0]       r_arid;
  logic                        r_rlast;
  logic                        r_ignore_begin;
  logic                        r_ignore_end;
  logic [OstWidth-1:0]         outstanding;

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, cmd_full, r_data_rdy, r_burst_done,
    output arready, cmd_en, cmd_instr, cmd_byte_addr, r_push, r_arid, r_rlast,
           r_ignore_begin, r_ignore_end, outstanding
  );

  modport master (
    output arid, araddr, arlen, arburst, arvalid, cmd_full, r_data_rdy, r_burst_done,
    input  arready, cmd_en, cmd_instr, cmd_byte_addr, r_push, r_arid, r_rlast,
           r_ignore_begin, r_ignore_end, outstanding
  );
endinterface

// File: rtl/ddr4_axi_ar_channel_mo.sv
// ddr4_axi_ar_channel_mo
//   Multi-outstanding AXI read-address channel for the DDR4 AXI slave. Each accepted AR
//   burst is split into MC read commands of C_BEATS_PER_CMD beats; every accepted command
//   pushes a tag (ID, last, ignore-begin/end) to the R channel. Up to C_MAX_OUTSTANDING
//   bursts may be accepted but not yet completed (completion = r_burst_done pulse).
// Ports
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : ddr4_axi_ar_channel_mo_if.slave (AR in, MC command out, R tags out)
//   perf_ar_cnt, perf_stall_cnt : saturating counters, present only when
//                  DDR4_AR_PERF_CNT_EN is defined
module ddr4_axi_ar_channel_mo #(
  parameter int unsigned C_ID_WIDTH        = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_MC_ADDR_WIDTH   = 30,
  parameter int unsigned C_DATA_WIDTH      = 128,
  parameter int unsigned C_BEATS_PER_CMD   = 4,
  parameter int unsigned C_MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ddr4_axi_ar_channel_mo_if.slave       bus
`ifdef DDR4_AR_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_ar_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int unsigned BeatBytes = C_DATA_WIDTH / 8;
  localparam int unsigned CmdBytes  = C_BEATS_PER_CMD * BeatBytes;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned BpcShift  = $clog2(C_BEATS_PER_CMD);
  localparam int unsigned OstWidth  = $clog2(C_MAX_OUTSTANDING + 1);

  typedef logic [C_AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [C_MC_ADDR_WIDTH-1:0]  mc_addr_t;
  typedef logic [OstWidth-1:0]         ost_t;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                 state_q, state_d;
  ost_t                   ost_q, ost_d;
  logic [C_ID_WIDTH-1:0]  id_q, id_d;
  addr_t                  addr_q, addr_d;
  logic                   wrap_q, wrap_d;
  addr_t                  wrap_lo_q, wrap_lo_d;
  addr_t                  wrap_hi_q, wrap_hi_d;
  logic [9:0]             cmds_left_q, cmds_left_d;
  logic                   first_q, first_d;
  logic                   off_nz_q, off_nz_d;
  logic                   end_part_q, end_part_d;

  // Burst decode of the presented AR request
  addr_t      req_beat_idx;
  logic [4:0] req_off;
  logic [9:0] req_total;
  logic [9:0] req_ncmd;
  logic       req_end_part;
  logic [8:0] req_len1;
  logic       req_wrap;
  addr_t      req_wrap_bytes;
  addr_t      req_wrap_lo;
  addr_t      req_cmd_addr;

  always_comb begin
    req_beat_idx   = bus.araddr >> BeatShift;
    req_off        = 5'(req_beat_idx & addr_t'(C_BEATS_PER_CMD - 1));
    // 10-bit sum: off up to 15 plus 256 beats cannot overflow
    req_total      = 10'(req_off) + 10'(bus.arlen) + 10'd1;
    req_ncmd       = (req_total + 10'(C_BEATS_PER_CMD - 1)) >> BpcShift;
    req_end_part   = (req_total & 10'(C_BEATS_PER_CMD - 1)) != 10'd0;
    req_len1       = 9'(bus.arlen) + 9'd1;
    req_wrap       = (bus.arburst == 2'b10) && (req_len1 >= 9'(C_BEATS_PER_CMD)) &&
                     (req_off == 5'd0);
    req_wrap_bytes = addr_t'(req_len1) << BeatShift;
    req_wrap_lo    = bus.araddr & ~(req_wrap_bytes - addr_t'(1));
    req_cmd_addr   = bus.araddr & ~addr_t'(CmdBytes - 1);
  end

  logic     ost_full;
  logic     arready;
  logic     handshake;
  logic     cmd_en;
  logic     accept;
  logic     last_cmd;
  logic     dec;
  mc_addr_t cmd_byte_addr;
  addr_t    addr_inc;

  // Outputs and accept strobes
  always_comb begin
    ost_full      = (ost_q == ost_t'(C_MAX_OUTSTANDING));
    arready       = 1'b0;
    cmd_en        = 1'b0;
    cmd_byte_addr = '0;
    accept        = 1'b0;
    last_cmd      = (cmds_left_q == 10'd1);
    unique case (state_q)
      StIdle:  arready = !ost_full;
      StIssue: begin
        cmd_en        = bus.r_data_rdy;
        cmd_byte_addr = addr_q[C_MC_ADDR_WIDTH-1:0] & ~mc_addr_t'(CmdBytes - 1);
        accept        = cmd_en && !bus.cmd_full;
      end
      default: ;
    endcase
    handshake = bus.arvalid && arready;
    dec       = bus.r_burst_done && (ost_q != '0);
  end

  assign bus.arready        = arready;
  assign bus.cmd_en         = cmd_en;
  assign bus.cmd_instr      = 3'b001;
  assign bus.cmd_byte_addr  = cmd_byte_addr;
  assign bus.r_push         = accept;
  assign bus.r_arid         = accept ? id_q : '0;
  assign bus.r_rlast        = accept && last_cmd;
  assign bus.r_ignore_begin = accept && first_q && off_nz_q;
  assign bus.r_ignore_end   = accept && last_cmd && end_part_q;
  assign bus.outstanding    = ost_q;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wrap_d      = wrap_q;
    wrap_lo_d   = wrap_lo_q;
    wrap_hi_d   = wrap_hi_q;
    cmds_left_d = cmds_left_q;
    first_d     = first_q;
    off_nz_d    = off_nz_q;
    end_part_d  = end_part_q;
    ost_d       = ost_q;

    // A wrap burst returns to its base once the next command hits the wrap boundary
    addr_inc = addr_q + addr_t'(CmdBytes);
    if (wrap_q && (addr_inc == wrap_hi_q)) begin
      addr_inc = wrap_lo_q;
    end

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d     = StIssue;
          id_d        = bus.arid;
          wrap_d      = req_wrap;
          wrap_lo_d   = req_wrap_lo;
          wrap_hi_d   = req_wrap_lo + req_wrap_bytes;
          addr_d      = req_wrap ? (bus.araddr & ~addr_t'(CmdBytes - 1)) : req_cmd_addr;
          cmds_left_d = req_ncmd;
          first_d     = 1'b1;
          off_nz_d    = !req_wrap && (req_off != 5'd0);
          end_part_d  = !req_wrap && req_end_part;
        end
      end
      StIssue: begin
        if (accept) begin
          addr_d      = addr_inc;
          cmds_left_d = cmds_left_q - 10'd1;
          first_d     = 1'b0;
          if (last_cmd) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case ({handshake, dec})
      2'b10:   ost_d = ost_q + ost_t'(1);
      2'b01:   ost_d = ost_q - ost_t'(1);
      default: ost_d = ost_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ost_q       <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      wrap_q      <= 1'b0;
      wrap_lo_q   <= '0;
      wrap_hi_q   <= '0;
      cmds_left_q <= '0;
      first_q     <= 1'b0;
      off_nz_q    <= 1'b0;
      end_part_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ost_q       <= ost_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wrap_q      <= wrap_d;
      wrap_lo_q   <= wrap_lo_d;
      wrap_hi_q   <= wrap_hi_d;
      cmds_left_q <= cmds_left_d;
      first_q     <= first_d;
      off_nz_q    <= off_nz_d;
      end_part_q  <= end_part_d;
    end
  end

`ifdef DDR4_AR_PERF_CNT_EN
  logic [31:0] perf_ar_q, perf_ar_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ar_d    = perf_ar_q;
    perf_stall_d = perf_stall_q;
    if (handshake && (perf_ar_q != 32'hFFFF_FFFF)) begin
      perf_ar_d = perf_ar_q + 32'd1;
    end
    if ((state_q == StIssue) && !accept && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_ar_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ar_q    <= perf_ar_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ar_cnt    = perf_ar_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ddr4_axi_ar_channel_mo.sv
// Bench for ddr4_axi_ar_channel_mo: a queue-based command model is checked against the
// DUT every cycle, plus literal expectations for the directed scenarios.
module tb_ddr4_axi_ar_channel_mo;
  localparam int unsigned IdW  = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned MW   = 30;
  localparam int unsigned DW   = 128;
  localparam int unsigned BPC  = 4;
  localparam int unsigned MAXO = 2;
  localparam longint unsigned BEAT = DW / 8;
  localparam longint unsigned CMDB = BPC * BEAT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddr4_axi_ar_channel_mo_if #(
    .C_ID_WIDTH(IdW), .C_AXI_ADDR_WIDTH(AW), .C_MC_ADDR_WIDTH(MW), .C_MAX_OUTSTANDING(MAXO)
  ) bus ();

`ifdef DDR4_AR_PERF_CNT_EN
  logic [31:0] perf_ar_cnt, perf_stall_cnt;
`endif

  ddr4_axi_ar_channel_mo #(
    .C_ID_WIDTH(IdW), .C_AXI_ADDR_WIDTH(AW), .C_MC_ADDR_WIDTH(MW), .C_DATA_WIDTH(DW),
    .C_BEATS_PER_CMD(BPC), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef DDR4_AR_PERF_CNT_EN
    ,
    .perf_ar_cnt(perf_ar_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [MW-1:0]  addr;
    logic           rlast;
    logic           ib;
    logic           ie;
    logic [IdW-1:0] id;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t log_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int model_cnt = 0;
  int unsigned model_ar = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Expected command list of one burst, straight from the burst rules
  function automatic void build(input logic [IdW-1:0] id, input logic [AW-1:0] addr,
                                input int len, input logic [1:0] burst);
    longint unsigned a, off, total, ncmd, wb, base, ca;
    bit wrap;
    cmd_t c;
    a     = longint'(addr);
    off   = (a % CMDB) / BEAT;
    total = off + longint'(len) + 1;
    ncmd  = (total + BPC - 1) / BPC;
    wrap  = (burst == 2'b10) && (len + 1 >= int'(BPC)) && (off == 0);
    wb    = longint'(len + 1) * BEAT;
    base  = a - (a % wb);
    for (longint unsigned i = 0; i < ncmd; i++) begin
      if (wrap) ca = base + ((a - base + i * CMDB) % wb);
      else      ca = (a - (a % CMDB)) + i * CMDB;
      c.addr  = MW'(ca & ((64'd1 << MW) - 1));
      c.rlast = (i == ncmd - 1);
      c.ib    = !wrap && (i == 0) && (off != 0);
      c.ie    = !wrap && (i == ncmd - 1) && ((total % BPC) != 0);
      c.id    = id;
      exp_q.push_back(c);
    end
  endfunction

  // Compare process: outputs are checked at negedge, then the model advances to the
  // state the DUT will hold after the coming posedge.
  always @(negedge clk) begin : cmp
    bit idle, e_ardy, e_en, e_push, hs, dec;
    logic [MW-1:0] e_addr;
    idle   = (exp_q.size() == 0);
    e_ardy = idle && (model_cnt < int'(MAXO));
    e_en   = !idle && bus.r_data_rdy;
    e_push = e_en && !bus.cmd_full;
    e_addr = idle ? '0 : exp_q[0].addr;
    if (armed) begin
      check("arready", bus.arready, e_ardy);
      check("cmd_en", bus.cmd_en, e_en);
      if (e_en) check("cmd_byte_addr", bus.cmd_byte_addr, e_addr);
      check("cmd_instr", bus.cmd_instr, 3'b001);
      check("r_push", bus.r_push, e_push);
      check("outstanding", bus.outstanding, model_cnt);
`ifdef DDR4_AR_PERF_CNT_EN
      check("perf_ar_cnt", perf_ar_cnt, model_ar);
`endif
      if (e_push && bus.r_push) begin
        check("r_arid", bus.r_arid, exp_q[0].id);
        check("r_rlast", bus.r_rlast, exp_q[0].rlast);
        check("r_ignore_begin", bus.r_ignore_begin, exp_q[0].ib);
        check("r_ignore_end", bus.r_ignore_end, exp_q[0].ie);
      end
      if (bus.r_push) begin
        log_q.push_back('{addr: bus.cmd_byte_addr, rlast: bus.r_rlast,
                          ib: bus.r_ignore_begin, ie: bus.r_ignore_end, id: bus.r_arid});
      end
    end
    if (!reset_n) begin
      exp_q.delete();
      model_cnt = 0;
      model_ar  = 0;
      armed     = 1'b1;
    end else if (armed) begin
      if (e_push) void'(exp_q.pop_front());
      hs  = bus.arvalid && e_ardy;
      dec = bus.r_burst_done && (model_cnt != 0);
      if (hs) begin
        build(bus.arid, bus.araddr, int'(bus.arlen), bus.arburst);
        model_ar++;
      end
      model_cnt = model_cnt + int'(hs) - int'(dec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [IdW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.arready;
      step();
    end
    bus.arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
  endtask

  task automatic wait_idle(input bit bp);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
      step();
      if (bp) begin
        bus.cmd_full   = ($urandom_range(0, 3) == 0);
        bus.r_data_rdy = ($urandom_range(0, 3) != 0);
      end
    end
    bus.cmd_full   = 1'b0;
    bus.r_data_rdy = 1'b1;
    if (!done) timeout("burst_complete");
  endtask

  task automatic pulse_done();
    bus.r_burst_done = 1'b1;
    step();
    bus.r_burst_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [IdW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [1:0]     burst;
  } ar_t;

  initial begin
    ar_t sweep[$];
    int n;
`ifdef DDR4_AR_PERF_CNT_EN
    logic [31:0] s0;
`endif
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = 2'b01;
    bus.arvalid = 1'b0; bus.cmd_full = 1'b0; bus.r_data_rdy = 1'b1; bus.r_burst_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_en", bus.cmd_en, 1'b0);
    check("reset_arready", bus.arready, 1'b1);
    check("reset_outstanding", bus.outstanding, 0);
    check("reset_r_push", bus.r_push, 1'b0);
    step();

    // 1: aligned INCR, two commands
    log_q.delete();
    send_ar(4'd1, 32'h40, 8'd7, 2'b01);
    wait_idle(1'b0);
    check("t1_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t1_addr0", log_q[0].addr, 30'h40);
      check("t1_addr1", log_q[1].addr, 30'h80);
      check("t1_rlast0", log_q[0].rlast, 1'b0);
      check("t1_rlast1", log_q[1].rlast, 1'b1);
      check("t1_ign", {log_q[0].ib, log_q[0].ie, log_q[1].ib, log_q[1].ie}, 4'b0000);
    end
    pulse_done();

    // 2: unaligned INCR, both ignore flags
    log_q.delete();
    send_ar(4'd2, 32'h10, 8'd5, 2'b01);
    wait_idle(1'b0);
    check("t2_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t2_addr0", log_q[0].addr, 30'h00);
      check("t2_addr1", log_q[1].addr, 30'h40);
      check("t2_ib0", log_q[0].ib, 1'b1);
      check("t2_ie0", log_q[0].ie, 1'b0);
      check("t2_ib1", log_q[1].ib, 1'b0);
      check("t2_ie1", log_q[1].ie, 1'b1);
      check("t2_id1", log_q[1].id, 4'd2);
    end
    pulse_done();

    // 3: WRAP to base
    log_q.delete();
    send_ar(4'd3, 32'hC0, 8'd7, 2'b10);
    wait_idle(1'b0);
    check("t3_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t3_addr0", log_q[0].addr, 30'hC0);
      check("t3_addr1", log_q[1].addr, 30'h80);
      check("t3_rlast1", log_q[1].rlast, 1'b1);
      check("t3_ign", {log_q[0].ib, log_q[0].ie, log_q[1].ib, log_q[1].ie}, 4'b0000);
    end
    pulse_done();

    // 4: outstanding limit
    send_ar(4'd4, 32'h0, 8'd3, 2'b01);
    wait_idle(1'b0);
    send_ar(4'd5, 32'h100, 8'd3, 2'b01);
    wait_idle(1'b0);
    @(negedge clk);
    check("t4_ost_full", bus.outstanding, 2);
    check("t4_arready_low", bus.arready, 1'b0);
    step();
    pulse_done();
    @(negedge clk);
    check("t4_arready_back", bus.arready, 1'b1);
    check("t4_ost_after", bus.outstanding, 1);
    step();
    pulse_done();

    // 5: cmd_full stall mid-burst
    log_q.delete();
    send_ar(4'd6, 32'h0, 8'd15, 2'b01);
    step();
    bus.cmd_full = 1'b1;
`ifdef DDR4_AR_PERF_CNT_EN
    s0 = perf_stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_cmd_en_held", bus.cmd_en, 1'b1);
      check("t5_addr_held", bus.cmd_byte_addr, 30'h40);
      check("t5_no_push", bus.r_push, 1'b0);
      step();
    end
    bus.cmd_full = 1'b0;
    @(negedge clk);
    check("t5_accept", bus.r_push, 1'b1);
    check("t5_accept_addr", bus.cmd_byte_addr, 30'h40);
`ifdef DDR4_AR_PERF_CNT_EN
    check("t5_stall_cnt", perf_stall_cnt, s0 + 32'd5);
`endif
    step();
    wait_idle(1'b0);
    check("t5_count", log_q.size(), 4);
    pulse_done();

    // 6: reset in the middle of a burst
    send_ar(4'd7, 32'h200, 8'd15, 2'b01);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_en", bus.cmd_en, 1'b0);
    check("t6_arready", bus.arready, 1'b1);
    check("t6_outstanding", bus.outstanding, 0);
    n = log_q.size();
    step();
    repeat (5) step();
    check("t6_no_push", log_q.size(), n);

    // Model-only sweep with backpressure
    sweep.push_back('{id: 4'd8,  addr: 32'h0000_0030, len: 8'd255, burst: 2'b01});
    sweep.push_back('{id: 4'd9,  addr: 32'hFFFF_FFC0, len: 8'd7,   burst: 2'b01});
    sweep.push_back('{id: 4'd10, addr: 32'h0000_01C0, len: 8'd15,  burst: 2'b10});
    sweep.push_back('{id: 4'd11, addr: 32'h0000_0050, len: 8'd3,   burst: 2'b10});
    sweep.push_back('{id: 4'd14, addr: 32'h7FFF_FF00, len: 8'd31,  burst: 2'b10});
    sweep.push_back('{id: 4'd13, addr: 32'h0000_0020, len: 8'd1,   burst: 2'b10});
    foreach (sweep[i]) begin
      send_ar(sweep[i].id, sweep[i].addr, sweep[i].len, sweep[i].burst);
      wait_idle(1'b1);
      pulse_done();
    end

    // FIXED burst, then a handshake coinciding with r_burst_done
    send_ar(4'd12, 32'h1000, 8'd0, 2'b00);
    wait_idle(1'b0);
    bus.r_burst_done = 1'b1;
    send_ar(4'd15, 32'h2000, 8'd3, 2'b01);
    bus.r_burst_done = 1'b0;
    wait_idle(1'b0);
    @(negedge clk);
    check("simul_done_ost", bus.outstanding, 1);
    step();
    pulse_done();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
